// File: rtl/mrelbp_pkg.sv
// mrelbp_pkg: constants and types shared by the MRELBP radius-8 window generator.
//   RADIUS / WIN   : sampling radius and the resulting square window side.
//   PIX_WIDTH      : default pixel width; pixel_t is the matching pixel type.
//   OFF_*          : the row/column offsets inside the window that carry taps.
//   NUM_ROWS       : number of window rows that need a horizontal shift register.
package mrelbp_pkg;

  localparam int RADIUS    = 8;
  localparam int WIN       = 2 * RADIUS + 1;
  localparam int PIX_WIDTH = 8;

  typedef logic [PIX_WIDTH-1:0] pixel_t;

  localparam int OFF_0  = 0;
  localparam int OFF_2  = 2;
  localparam int OFF_3  = 3;
  localparam int OFF_8  = 8;
  localparam int OFF_13 = 13;
  localparam int OFF_14 = 14;
  localparam int OFF_16 = 16;

  localparam int NUM_ROWS = 7;

endpackage

// File: rtl/mrelbp_window_gen_r8_line_buffer.sv
// line_buffer: circular delay line, advances only when en is high.
//   clk, rst_n : clock, synchronous active-low reset (pointer only; RAM keeps data).
//   en         : advance one position (read old entry, write din, bump pointer).
//   din        : value written at the current pointer.
//   dout       : registered value read from the current pointer before the write.
// A value written on enable N appears on dout after enable N+DEPTH.
module line_buffer
  import mrelbp_pkg::*;
#(
  parameter int WIDTH = PIX_WIDTH,
  parameter int DEPTH = 63
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    ptr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (en) begin
      if (ptr == AW'(DEPTH - 1)) ptr <= '0;
      else                       ptr <= ptr + 1'b1;
    end
  end

  // Read-before-write on the same slot: the old entry leaves as the new one enters.
  always_ff @(posedge clk) begin
    if (en) begin
      dout     <= mem[ptr];
      mem[ptr] <= din;
    end
  end

endmodule

// File: rtl/mrelbp_window_gen_r8.sv
// mrelbp_window_gen_r8: streaming 17x17 window generator for the radius-8,
// 8-point MRELBP sampler. Only the 20 taps the sampler uses are presented.
//   i_clk, i_rst_n : clock, synchronous active-low reset.
//   i_valid        : i_pixel is accepted this cycle (no backpressure).
//   i_pixel        : raster-order pixel stream.
//   o_valid        : one-cycle pulse, taps hold a complete in-image window.
//   o_frame_done   : pulses together with the last o_valid of a frame.
//   o_pixel_<r><c> : window tap w[r][c]; row 16 / column 16 is the newest pixel.
// Taps and o_valid are registered: the window of pixel (y, x) is presented the
// cycle after that pixel is accepted, for y >= 16 and x >= 16. Taps hold otherwise.
module mrelbp_window_gen_r8
  import mrelbp_pkg::*;
#(
  parameter int WIDTH = PIX_WIDTH,
  parameter int IMG_W = 64,
  parameter int IMG_H = 64
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_pixel,
  output logic             o_valid,
  output logic             o_frame_done,
  output logic [WIDTH-1:0] o_pixel_08,
  output logic [WIDTH-1:0] o_pixel_22,
  output logic [WIDTH-1:0] o_pixel_23,
  output logic [WIDTH-1:0] o_pixel_213,
  output logic [WIDTH-1:0] o_pixel_214,
  output logic [WIDTH-1:0] o_pixel_32,
  output logic [WIDTH-1:0] o_pixel_33,
  output logic [WIDTH-1:0] o_pixel_313,
  output logic [WIDTH-1:0] o_pixel_314,
  output logic [WIDTH-1:0] o_pixel_80,
  output logic [WIDTH-1:0] o_pixel_816,
  output logic [WIDTH-1:0] o_pixel_132,
  output logic [WIDTH-1:0] o_pixel_133,
  output logic [WIDTH-1:0] o_pixel_1313,
  output logic [WIDTH-1:0] o_pixel_1314,
  output logic [WIDTH-1:0] o_pixel_142,
  output logic [WIDTH-1:0] o_pixel_143,
  output logic [WIDTH-1:0] o_pixel_1413,
  output logic [WIDTH-1:0] o_pixel_1414,
  output logic [WIDTH-1:0] o_pixel_168
);

  localparam int NLB = WIN - 1;
  localparam int CW  = $clog2(IMG_W);
  localparam int RW  = $clog2(IMG_H);

  // ---------------- raster position ----------------
  logic [CW-1:0] col_cnt;
  logic [RW-1:0] row_cnt;
  logic          col_last;
  logic          row_last;
  logic          fire;
  logic          last_win;

  assign col_last = (col_cnt == CW'(IMG_W - 1));
  assign row_last = (row_cnt == RW'(IMG_H - 1));

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      col_cnt <= '0;
      row_cnt <= '0;
    end else if (i_valid) begin
      if (col_last) begin
        col_cnt <= '0;
        row_cnt <= row_last ? '0 : row_cnt + 1'b1;
      end else begin
        col_cnt <= col_cnt + 1'b1;
      end
    end
  end

  // A window is complete once 16 earlier rows and 16 earlier columns exist.
  // Requiring x >= 16 also guarantees all 17 shift stages hold this row's data.
  assign fire     = i_valid && (row_cnt >= RW'(OFF_16)) && (col_cnt >= CW'(OFF_16));
  assign last_win = fire && row_last && col_last;

  // ---------------- line buffers ----------------
  // The registered read adds one accept of delay, so a depth of IMG_W-1 gives
  // each stage a total row delay of exactly IMG_W accepted pixels at its output
  // as seen by the next accept edge.
  logic [WIDTH-1:0] lb_in  [NLB];
  logic [WIDTH-1:0] lb_out [NLB];

  assign lb_in[0] = i_pixel;

  for (genvar k = 0; k < NLB; k++) begin : g_lb
    if (k > 0) begin : g_chain
      assign lb_in[k] = lb_out[k-1];
    end
    line_buffer #(
      .WIDTH (WIDTH),
      .DEPTH (IMG_W - 1)
    ) u_lb (
      .clk   (i_clk),
      .rst_n (i_rst_n),
      .en    (i_valid),
      .din   (lb_in[k]),
      .dout  (lb_out[k])
    );
  end

  // ---------------- tapped row streams ----------------
  // Window row r is the stream delayed by (16 - r) rows; stream d (d >= 1) is lb_out[d-1].
  // Slot order: 0 -> r0, 1 -> r2, 2 -> r3, 3 -> r8, 4 -> r13, 5 -> r14, 6 -> r16.
  logic [WIDTH-1:0] row_in [NUM_ROWS];

  assign row_in[0] = lb_out[OFF_16 - OFF_0  - 1];
  assign row_in[1] = lb_out[OFF_16 - OFF_2  - 1];
  assign row_in[2] = lb_out[OFF_16 - OFF_3  - 1];
  assign row_in[3] = lb_out[OFF_16 - OFF_8  - 1];
  assign row_in[4] = lb_out[OFF_16 - OFF_13 - 1];
  assign row_in[5] = lb_out[OFF_16 - OFF_14 - 1];
  assign row_in[6] = i_pixel;

  // ---------------- horizontal shift registers ----------------
  // sr holds columns 1..16 of the window as of the previous accept; win is the
  // window including the pixel being accepted now (column 0 falls out of sr).
  logic [WIDTH-1:0] sr  [NUM_ROWS][1:WIN-1];
  logic [WIDTH-1:0] win [NUM_ROWS][WIN];

  always_comb begin
    for (int j = 0; j < NUM_ROWS; j++) begin
      for (int c = 0; c < WIN - 1; c++) begin
        win[j][c] = sr[j][c+1];
      end
      win[j][WIN-1] = row_in[j];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_valid) begin
      for (int j = 0; j < NUM_ROWS; j++) begin
        for (int c = 1; c < WIN; c++) begin
          sr[j][c] <= win[j][c];
        end
      end
    end
  end

  // ---------------- registered outputs ----------------
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_valid      <= 1'b0;
      o_frame_done <= 1'b0;
      o_pixel_08   <= '0;
      o_pixel_22   <= '0;
      o_pixel_23   <= '0;
      o_pixel_213  <= '0;
      o_pixel_214  <= '0;
      o_pixel_32   <= '0;
      o_pixel_33   <= '0;
      o_pixel_313  <= '0;
      o_pixel_314  <= '0;
      o_pixel_80   <= '0;
      o_pixel_816  <= '0;
      o_pixel_132  <= '0;
      o_pixel_133  <= '0;
      o_pixel_1313 <= '0;
      o_pixel_1314 <= '0;
      o_pixel_142  <= '0;
      o_pixel_143  <= '0;
      o_pixel_1413 <= '0;
      o_pixel_1414 <= '0;
      o_pixel_168  <= '0;
    end else begin
      o_valid      <= fire;
      o_frame_done <= last_win;
      if (fire) begin
        o_pixel_08   <= win[0][OFF_8];
        o_pixel_22   <= win[1][OFF_2];
        o_pixel_23   <= win[1][OFF_3];
        o_pixel_213  <= win[1][OFF_13];
        o_pixel_214  <= win[1][OFF_14];
        o_pixel_32   <= win[2][OFF_2];
        o_pixel_33   <= win[2][OFF_3];
        o_pixel_313  <= win[2][OFF_13];
        o_pixel_314  <= win[2][OFF_14];
        o_pixel_80   <= win[3][OFF_0];
        o_pixel_816  <= win[3][OFF_16];
        o_pixel_132  <= win[4][OFF_2];
        o_pixel_133  <= win[4][OFF_3];
        o_pixel_1313 <= win[4][OFF_13];
        o_pixel_1314 <= win[4][OFF_14];
        o_pixel_142  <= win[5][OFF_2];
        o_pixel_143  <= win[5][OFF_3];
        o_pixel_1413 <= win[5][OFF_13];
        o_pixel_1414 <= win[5][OFF_14];
        o_pixel_168  <= win[6][OFF_8];
      end
    end
  end

endmodule

// File: tb/tb_mrelbp_window_gen_r8.sv
// Bench for mrelbp_window_gen_r8 on a 20x20 image.
// Handshake: a pixel is accepted on every rising edge where i_valid = 1; the
// window for accepted pixel (y, x) with y >= 16 and x >= 16 must appear with
// o_valid = 1 exactly one cycle later; outputs hold while o_valid = 0.
module tb_mrelbp_window_gen_r8;

  localparam int W   = 8;
  localparam int IW  = 20;
  localparam int IH  = 20;
  localparam int NT  = 20;
  localparam int EW  = NT * W + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  logic i_valid;
  logic [W-1:0] i_pixel;
  always #5 clk = ~clk;

  logic o_valid, o_frame_done;
  logic [W-1:0] o_pixel_08, o_pixel_22, o_pixel_23, o_pixel_213, o_pixel_214;
  logic [W-1:0] o_pixel_32, o_pixel_33, o_pixel_313, o_pixel_314, o_pixel_80, o_pixel_816;
  logic [W-1:0] o_pixel_132, o_pixel_133, o_pixel_1313, o_pixel_1314;
  logic [W-1:0] o_pixel_142, o_pixel_143, o_pixel_1413, o_pixel_1414, o_pixel_168;

  mrelbp_window_gen_r8 #(.WIDTH(W), .IMG_W(IW), .IMG_H(IH)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .i_pixel(i_pixel),
    .o_valid(o_valid), .o_frame_done(o_frame_done),
    .o_pixel_08(o_pixel_08), .o_pixel_22(o_pixel_22), .o_pixel_23(o_pixel_23),
    .o_pixel_213(o_pixel_213), .o_pixel_214(o_pixel_214),
    .o_pixel_32(o_pixel_32), .o_pixel_33(o_pixel_33), .o_pixel_313(o_pixel_313),
    .o_pixel_314(o_pixel_314), .o_pixel_80(o_pixel_80), .o_pixel_816(o_pixel_816),
    .o_pixel_132(o_pixel_132), .o_pixel_133(o_pixel_133), .o_pixel_1313(o_pixel_1313),
    .o_pixel_1314(o_pixel_1314), .o_pixel_142(o_pixel_142), .o_pixel_143(o_pixel_143),
    .o_pixel_1413(o_pixel_1413), .o_pixel_1414(o_pixel_1414), .o_pixel_168(o_pixel_168)
  );

  // Tap i sits at bits [i*8 +: 8]; frame_done at bit NT*W.
  logic [EW-1:0] act;
  assign act = {o_frame_done, o_pixel_168, o_pixel_1414, o_pixel_1413, o_pixel_143,
                o_pixel_142, o_pixel_1314, o_pixel_1313, o_pixel_133, o_pixel_132,
                o_pixel_816, o_pixel_80, o_pixel_314, o_pixel_313, o_pixel_33,
                o_pixel_32, o_pixel_214, o_pixel_213, o_pixel_23, o_pixel_22, o_pixel_08};

  int tr [NT] = '{0, 2, 2, 2, 2, 3, 3, 3, 3, 8, 8, 13, 13, 13, 13, 14, 14, 14, 14, 16};
  int tc [NT] = '{8, 2, 3, 13, 14, 2, 3, 13, 14, 0, 16, 2, 3, 13, 14, 2, 3, 13, 14, 8};

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  int            cyc_q[$];
  logic [EW-1:0] last_exp;
  logic [EW-1:0] cap [128];
  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int n_valid = 0;
  int pop_idx = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [EW:0] a, input logic [EW:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, a, e, $time);
    end
  endtask

  function automatic logic [W-1:0] pix(input int off, input int y, input int x);
    return W'((y * IW + x + off) % 256);
  endfunction

  function automatic logic [W-1:0] tap_of(input logic [EW-1:0] v, input int i);
    return v[i*W +: W];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      i_valid = 1'b0;
    end
  endtask

  task automatic send_frame(input int off, input int gap_max, input int stop_n);
    int n;
    logic [EW-1:0] item;
    n = 0;
    for (int y = 0; y < IH; y++) begin
      for (int x = 0; x < IW; x++) begin
        if (stop_n >= 0 && n == stop_n) begin
          idle(1);
          return;
        end
        if (gap_max > 0) idle($urandom_range(gap_max, 0));
        @(negedge clk);
        i_valid = 1'b1;
        i_pixel = pix(off, y, x);
        if (y >= 16 && x >= 16) begin
          item = '0;
          for (int i = 0; i < NT; i++) item[i*W +: W] = pix(off, y - 16 + tr[i], x - 16 + tc[i]);
          item[NT*W] = (y == IH - 1 && x == IW - 1);
          exp_q.push_back(item);
          cyc_q.push_back(cyc + 1);
        end
        n++;
      end
    end
    idle(1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    i_valid = 1'b0;
    i_pixel = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- monitor ----------------
  always begin
    logic [EW-1:0] item;
    @(posedge clk);
    #1;
    if (cyc >= 1) begin
      if (o_valid === 1'b1) n_valid++;
      if (!rst_n) begin
        last_exp = '0;
        chk("reset_outputs", {o_valid, act}, '0);
      end else if (cyc_q.size() > 0 && cyc_q[0] == cyc) begin
        item = exp_q.pop_front();
        void'(cyc_q.pop_front());
        chk("window", {o_valid, act}, {1'b1, item});
        if (pop_idx < 128) cap[pop_idx] = act;
        pop_idx++;
        last_exp = item;
      end else begin
        chk("idle_hold", {o_valid, act}, {1'b0, 1'b0, last_exp[NT*W-1:0]});
      end
    end
  end

  // ---------------- stimulus + report ----------------
  initial begin
    logic [EW-1:0] v;
    rst_n = 1'b0;
    i_valid = 1'b0;
    i_pixel = '0;
    last_exp = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    send_frame(0, 0, -1);     // continuous frame
    send_frame(0, 5, -1);     // same frame with random gaps
    send_frame(0, 0, -1);     // back-to-back frames
    send_frame(100, 0, -1);
    send_frame(0, 0, 358);    // stop after pixel (17, 17)
    do_reset();
    send_frame(0, 0, -1);     // fresh frame after reset
    idle(5);

    chk("queue_drained", EW'(exp_q.size()) , '0);
    chk("pulse_count", EW'(n_valid), EW'(86));

    v = cap[0];
    chk("first_08",  EW'(tap_of(v, 0)),  EW'(8));
    chk("first_22",  EW'(tap_of(v, 1)),  EW'(42));
    chk("first_80",  EW'(tap_of(v, 9)),  EW'(160));
    chk("first_816", EW'(tap_of(v, 10)), EW'(176));
    chk("first_168", EW'(tap_of(v, 19)), EW'(72));
    chk("first_fd",  EW'(v[NT*W]),       EW'(0));
    v = cap[1];
    chk("second_816", EW'(tap_of(v, 10)), EW'(177));
    v = cap[4];
    chk("row17_80", EW'(tap_of(v, 9)), EW'(180));
    v = cap[15];
    chk("frame_done_16th", EW'(v[NT*W]), EW'(1));
    v = cap[48];
    chk("frame2_08", EW'(tap_of(v, 0)), EW'(108));
    v = cap[70];
    chk("after_reset_08",  EW'(tap_of(v, 0)),  EW'(8));
    chk("after_reset_816", EW'(tap_of(v, 10)), EW'(176));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mrelbp_window_gen_r8.md
Name: mrelbp_window_gen_r8

Overview:
Streaming neighbourhood generator that produces the pixel taps for the radius-8, 8-point MRELBP sampling stage (interpolation_8).
- Accepts a raster-order pixel stream, one pixel per accepted cycle.
- Keeps 16 line buffers plus horizontal shift registers, forming a sliding 17x17 window.
- Presents only the 20 taps the sampler needs, registered, with a valid strobe whenever the window lies fully inside the image.

Parameters:
WIDTH, 8, pixel width in bits.
IMG_W, 64, image width in pixels; must be >= 17.
IMG_H, 64, image height in pixels; must be >= 17.

Ports:
i_clk  input  1  clock.
i_rst_n  input  1  reset; synchronous, active-low.
i_valid  input  1  i_pixel is valid this cycle; pixel is accepted on this cycle.
i_pixel  input  WIDTH  raster-order pixel, row-major, top-left first.
o_valid  output  1  taps below hold a complete in-image window, one cycle pulse per window.
o_frame_done  output  1  one-cycle pulse coincident with the last o_valid of a frame.
o_pixel_08, o_pixel_22, o_pixel_23, o_pixel_213, o_pixel_214  output  WIDTH each  window taps w[r][c], named o_pixel_<r><c>.
o_pixel_32, o_pixel_33, o_pixel_313, o_pixel_314, o_pixel_80, o_pixel_816  output  WIDTH each  window taps.
o_pixel_132, o_pixel_133, o_pixel_1313, o_pixel_1314  output  WIDTH each  window taps.
o_pixel_142, o_pixel_143, o_pixel_1413, o_pixel_1414, o_pixel_168  output  WIDTH each  window taps.

Behaviour:
- Window geometry:
  - w[r][c], r = 0..16, c = 0..16.
  - Row 16 is the current input row; row 0 is 16 rows earlier.
  - Column 16 is the pixel just accepted; column 0 is 16 pixels earlier.
  - The window centre w[8][8] is image pixel (y-8, x-8), where (y, x) is the coordinate of the accepted pixel.
- Counters:
  - col_cnt runs 0..IMG_W-1 and row_cnt runs 0..IMG_H-1; both advance only when i_valid = 1.
  - col_cnt wraps to 0 at IMG_W-1 and increments row_cnt.
  - Both counters wrap to 0 after the pixel at (IMG_H-1, IMG_W-1).
- Line buffers:
  - 16 cascaded FIFOs, each IMG_W deep; buffer k feeds buffer k+1.
  - They advance only when i_valid = 1; there is no movement on idle cycles.
  - Horizontal 17-stage shift registers are needed only for rows 0, 2, 3, 8, 13, 14, 16; they also shift only on i_valid.
- Output timing:
  - On the cycle after accepting pixel (y, x) with y >= 16 and x >= 16, o_valid = 1 and all 20 taps reflect that window. Latency is 1 cycle.
  - Otherwise o_valid = 0 and the taps hold their last values.
- Window count: exactly (IMG_H-16)*(IMG_W-16) o_valid pulses per frame.
- Row edges: no window wraps across rows, since x < 16 suppresses o_valid; stale columns from the previous row are never exposed.
- Frame end: o_frame_done = 1 together with o_valid for the window of pixel (IMG_H-1, IMG_W-1).
- Next frame:
  - Counters restart at (0, 0); line buffer contents are not cleared.
  - No o_valid occurs until row 16 of the new frame, so old-frame data is never exposed.
- Idle cycles: gaps in i_valid of any length are legal and do not alter state.
- Reset (i_rst_n = 0 at a rising edge):
  - col_cnt, row_cnt, o_valid, o_frame_done and all taps go to 0.
  - Line buffer RAM is not reset.
  - Reset mid-frame discards the partial frame; the next accepted pixel is (0, 0).
- There is no backpressure; the downstream sampler is combinational and always ready.

Decomposition:
- Package mrelbp_pkg:
  - localparam RADIUS = 8, WIN = 2*RADIUS+1.
  - Tap offset constants: 0, 2, 3, 8, 13, 14, 16.
  - Shared pixel typedef sized by WIDTH.
- Sub-module line_buffer (WIDTH, DEPTH):
  - Circular buffer with an enable-gated read/write pointer.
  - One read-before-write per enable, output registered.
  - Instantiated 16 times in a generate loop.

Test Plan:
- IMG_W = IMG_H = 20; pixel value = (y*20+x) mod 256; continuous i_valid.
  - First o_valid occurs one cycle after the 337th accepted pixel.
  - Taps: o_pixel_08 = 8, o_pixel_22 = 42, o_pixel_80 = 160, o_pixel_816 = 176, o_pixel_168 = 72.
- Same frame: exactly 16 o_valid pulses.
  - Second window o_pixel_816 = 177.
  - Window for pixel (17, 16): o_pixel_80 = 180.
  - o_frame_done fires only with the 16th pulse.
- Random 0–5 cycle gaps in i_valid -> identical tap sequence to the continuous run; taps stable during gaps.
- Two back-to-back frames, second with pattern +100 -> no o_valid in the first 336 pixels of frame 2; first frame-2 window o_pixel_08 = 108.
- Reset asserted mid-row 17, then a fresh frame -> all outputs 0 during reset; first o_valid again after the 337th pixel, with the same tap values as scenario 1.
